fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter QUEUE_DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 imem_req  output  1  instruction memory read request, address valid this cycle.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_rdata  input  32  read data, returned exactly one cycle after imem_req.
REQ-008 instr  output  32  head-of-queue instruction to decoder; 32'h0 when queue empty.
REQ-009 instr_pc  output  32  PC of head instruction; 32'h0 when queue empty.
REQ-010 instr_valid  output  1  head entry is valid.
REQ-011 decode_ready  input  1  decoder accepts head this cycle.
REQ-012 redirect_valid  input  1  branch/flush request.
REQ-013 redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0.

Function
REQ-014 The block SHALL hold fetch_pc, a 1-bit inflight flag (with captured PC), and a circular queue of {instr, pc} entries with wrapping read/write pointers and an occupancy count 0..QUEUE_DEPTH.
REQ-015 Handshake: an entry SHALL pop when instr_valid && decode_ready && !redirect_valid; instr/instr_pc SHALL be show-ahead (combinational from head).
REQ-016 imem_req SHALL assert when !redirect_valid && (count + inflight) < QUEUE_DEPTH; the pop of the same cycle SHALL NOT count as free space.
REQ-017 On imem_req, imem_addr = fetch_pc; fetch_pc SHALL advance by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-018 inflight SHALL set the cycle after imem_req; imem_rdata SHALL be pushed with the captured PC in that cycle; inflight clears unless a new request is issued.
REQ-019 Latency: request in cycle N -> data pushed at end of N+1 -> instr_valid in N+2 (empty-queue case).
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; credit rule REQ-016 guarantees no push to a full queue.
REQ-021 Redirect cycle: queue flushed (count=0, pointers=0), inflight cleared and any response arriving the next cycle discarded, fetch_pc <= {redirect_pc[31:2],2'b00}, no imem_req issued.
REQ-022 Redirect with a concurrent pop or push: redirect SHALL win; neither takes effect.
REQ-023 First request after redirect SHALL be in the cycle following redirect, address redirect_pc.
REQ-024 Back-to-back redirects: only the last redirect_pc SHALL be used.
REQ-025 With decode_ready held high and no redirect, steady-state throughput SHALL be one instruction per cycle.

Reset
REQ-026 While rst high: imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, count=0, pointers=0, inflight=0, fetch_pc=RESET_PC.
REQ-027 Reset asserted mid-operation SHALL discard all queued and inflight data immediately, independent of clk.
REQ-028 First imem_req SHALL occur in the first rising edge cycle after rst deasserts, address RESET_PC.

Structure
REQ-029 Shared package riscv_pkg SHALL hold XLEN=32, RESET_PC default, QUEUE_DEPTH default, NOP_INSTR=32'h0.
REQ-030 Queue storage/pointers SHALL be one sub-module fetch_queue (show-ahead FIFO with flush input); PC/credit logic stays in fetch_unit.
REQ-031 instr output SHALL connect directly to the existing decoder's instr input without extra registering.

Verification
REQ-032 Reset release, decode_ready=1, memory returns addr as data -> imem_addr 0,4,8,...; instr_valid first high 2 cycles after first req; instr_pc 0,4,8 one per cycle.
REQ-033 decode_ready=0 for 10 cycles -> exactly 4 requests (0..12), count=4, imem_req low; raise ready -> pops 0,4,8,12 then fetch resumes at 16.
REQ-034 Redirect to 32'h0000_0103 with inflight request and 3 queued -> next cycle instr_valid=0, stale response dropped, next imem_addr=32'h100, instr_pc 32'h100 two cycles later.
REQ-035 Redirect asserted in the same cycle as a valid pop -> head not consumed by decoder count, queue empty next cycle.
REQ-036 redirect_pc=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 rst pulsed asynchronously between edges while queue full -> all outputs zero immediately; first req after release at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch path: widths, defaults and the queue entry layout.
package riscv_pkg;
  localparam int unsigned XLEN            = 32;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam int unsigned QUEUE_DEPTH_DEF = 4;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Show-ahead circular FIFO of {instr, pc} entries; flush wins over push and pop.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = QUEUE_DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_valid;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push && !i_flush && !w_full;
  assign w_pop   = i_pop && !i_flush && w_valid;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_data;
  end

  always_comb begin
    o_head = '{instr: NOP_INSTR, pc: '0};
    if (w_valid) o_head = r_mem[r_rptr];
  end

  assign o_valid = w_valid;
  assign o_count = r_count;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_flush && w_full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, single-outstanding memory credit and redirect handling.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            decode_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_credit;
  logic            w_req;
  logic            w_pop;
  logic            w_q_valid;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;

  // The outstanding request reserves a slot, so a push can never hit a full queue.
  assign w_credit = w_count + CW'(r_inflight);
  assign w_req    = !rst && !redirect_valid && (w_credit < CW'(QUEUE_DEPTH));
  assign w_pop    = w_q_valid && decode_ready && !redirect_valid;

  assign w_push_data = '{instr: imem_rdata, pc: r_inflight_pc};

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (redirect_valid),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (w_q_valid),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) r_inflight_pc <= r_fetch_pc;
      if (redirect_valid)  r_fetch_pc <= pc_align(redirect_pc);
      else if (w_req)      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = w_req ? r_fetch_pc : '0;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign instr_valid = w_q_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected instruction stream queued by stimulus, checked by a monitor.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        decode_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .decode_ready   (decode_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // Memory: one-cycle read latency, garbage on idle cycles.
  always @(posedge clk) imem_rdata <= imem_req ? mem_f(imem_addr) : $urandom;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_req = 0;
  int n_pop = 0;
  int first_req = -1;
  bit wait_valid = 1'b0;
  bit exp_req_now = 1'b0;
  logic [31:0] exp_fetch = RPC;
  logic [31:0] sb_pc[$];
  logic [31:0] sb_next;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic sb_refill();
    while (sb_pc.size() < 16) begin
      sb_pc.push_back(sb_next);
      sb_next = sb_next + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    sb_pc.delete();
    sb_next = {pc[31:2], 2'b00};
    sb_refill();
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [31:0] epc;
    cyc++;
    if (rst) begin
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      exp_fetch   = RPC;
      exp_req_now = 1'b1;
      wait_valid  = 1'b1;
      first_req   = -1;
    end else begin
      if (!instr_valid) begin
        chk("empty_instr", instr, 32'h0);
        chk("empty_pc", instr_pc, 32'h0);
      end
      if (exp_req_now && !redirect_valid) begin
        chk("first_req", {31'b0, imem_req}, 32'h1);
        exp_req_now = 1'b0;
      end
      if (imem_req) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        n_req++;
        if (first_req < 0) first_req = cyc;
      end
      if (wait_valid && instr_valid) begin
        chk("latency", 32'(cyc - first_req), 32'd2);
        wait_valid = 1'b0;
      end
      if (instr_valid && decode_ready && !redirect_valid) begin
        n_pop++;
        if (sb_pc.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          epc = sb_pc.pop_front();
          chk("pop_pc", instr_pc, epc);
          chk("pop_instr", instr, mem_f(epc));
        end
      end
      if (redirect_valid) begin
        chk("redir_noreq", {31'b0, imem_req}, 32'h0);
        exp_fetch   = {redirect_pc[31:2], 2'b00};
        exp_req_now = 1'b1;
        wait_valid  = 1'b1;
        first_req   = -1;
      end
    end
  end

  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    decode_ready   = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (redir) sb_restart(rpc);
    sb_refill();
  endtask

  task automatic release_rst(input logic rdy);
    @(posedge clk);
    #1;
    rst = 1'b0;
    decode_ready = rdy;
    redirect_valid = 1'b0;
  endtask

  initial begin
    int p0;
    int r0;
    sb_restart(RPC);
    repeat (3) step(1'b0, 1'b0, 32'h0);

    // Reset release with ready high: sequential stream, 1 instr/cycle.
    release_rst(1'b1);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    p0 = n_pop;
    repeat (10) step(1'b1, 1'b0, 32'h0);
    chk("throughput", 32'(n_pop - p0), 32'd10);

    // Stall: exactly QUEUE_DEPTH requests then credit exhausted.
    @(posedge clk); #1 rst = 1'b1; sb_restart(RPC);
    step(1'b0, 1'b0, 32'h0);
    release_rst(1'b0);
    r0 = n_req;
    repeat (10) step(1'b0, 1'b0, 32'h0);
    chk("stall_reqs", 32'(n_req - r0), 32'd4);
    chk("stall_req_low", {31'b0, imem_req}, 32'h0);
    chk("stall_full_valid", {31'b0, instr_valid}, 32'h1);
    repeat (12) step(1'b1, 1'b0, 32'h0);

    // Redirect with work queued and a request in flight.
    repeat (2) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0103);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_flush", {31'b0, instr_valid}, 32'h0);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Redirect concurrent with a valid pop.
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_pop_flush", {31'b0, instr_valid}, 32'h0);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Address wrap, then back-to-back redirects.
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (8) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0300);
    step(1'b1, 1'b1, 32'h0000_0402);
    repeat (8) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset while full.
    repeat (10) step(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    sb_restart(RPC);
    #1;
    chk("async_valid", {31'b0, instr_valid}, 32'h0);
    chk("async_instr", instr, 32'h0);
    chk("async_pc", instr_pc, 32'h0);
    chk("async_req", {31'b0, imem_req}, 32'h0);
    chk("async_addr", imem_addr, 32'h0);
    @(posedge clk);
    release_rst(1'b1);
    repeat (10) step(1'b1, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic rd;
      logic rv;
      rd = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 24) == 0);
      step(rd, rv, $urandom);
    end
    repeat (8) step(1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
